// File: rtl/param_pkg.sv
// Shared types and constants for the parameter prefetch unit: FSM states,
// word width, layer/neuron limits and the request stream tags.
package param_pkg;

  localparam int unsigned DW          = 16;
  localparam int unsigned MAX_LAYERS  = 5;
  localparam int unsigned MAX_NEURONS = 64;
  localparam int unsigned NW          = $clog2(MAX_NEURONS);
  localparam int unsigned TOT_W       = 15;

  localparam logic TAG_W = 1'b0;
  localparam logic TAG_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/param_fifo.sv
// Synchronous prefetch FIFO with a combinational head (0 when empty).
// A pop on empty is ignored; a push when full is accepted only alongside a pop.
module param_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DW-1:0]                wdata,
  output logic [DW-1:0]                head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == OW'(DEPTH));
  assign count   = cnt_q;
  assign head    = empty ? '0 : mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) rd_d = rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + OW'(1);
      2'b01:   cnt_d = cnt_q - OW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_prefetch_unit.sv
// Walks the layer config, then streams weight/bias words from parameter memory
// into two prefetch FIFOs. Optional PARAM_CHECKSUM_EN builds the pop checksum.
module param_prefetch_unit #(
  parameter int unsigned DW         = param_pkg::DW,
  parameter int unsigned AW         = 15,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned WBASE      = 0,
  parameter int unsigned BBASE      = 20480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [5:0]    no_layers,
  input  logic [5:0]    n_in,
  input  logic [5:0]    nl1,
  input  logic [5:0]    nl2,
  input  logic [5:0]    nl3,
  input  logic [5:0]    nl4,
  input  logic [5:0]    nl5,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          weight_en,
  input  logic          bias_en,
  output logic [DW-1:0] wt_in,
  output logic [DW-1:0] bias_in,
  output logic          wt_valid,
  output logic          bias_valid,
  output logic          busy,
  output logic          done,
  output logic          underrun,
  output logic [DW-1:0] param_csum
);

  import param_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH + MEM_LAT + 1);
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [NW-1:0]      prev_q, prev_d;
  logic [TOT_W-1:0]   wt_tot_q, wt_tot_d, b_tot_q, b_tot_d;
  logic [TOT_W-1:0]   w_cnt_q, w_cnt_d, b_cnt_q, b_cnt_d;
  logic               rr_q, rr_d;
  logic [MEM_LAT-1:0] pv_q, pv_d, pt_q, pt_d;
  logic               underrun_q, underrun_d;

  logic [2:0]    nl_eff;
  logic [NW-1:0] n_cur, n_prev;
  logic [CW-1:0] infl_w, infl_b;
  logic          w_elig, b_elig, grant_w, grant_b, start_acc;
  logic          w_push, b_push, w_full, b_full, w_empty, b_empty;
  logic [OW-1:0] w_count, b_count;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign nl_eff    = (no_layers > 6'(MAX_LAYERS)) ? 3'(MAX_LAYERS) : no_layers[2:0];
  assign n_prev    = (idx_q == 3'd0) ? n_in : prev_q;

  always_comb begin
    case (idx_q)
      3'd0:    n_cur = nl1;
      3'd1:    n_cur = nl2;
      3'd2:    n_cur = nl3;
      3'd3:    n_cur = nl4;
      default: n_cur = nl5;
    endcase
  end

  // Credits count words already tagged in the latency pipe as if they were queued.
  always_comb begin
    infl_w = '0;
    infl_b = '0;
    for (int unsigned i = 0; i < MEM_LAT; i++) begin
      if (pv_q[i] && pt_q[i] == TAG_B) infl_b = infl_b + CW'(1);
      if (pv_q[i] && pt_q[i] == TAG_W) infl_w = infl_w + CW'(1);
    end
  end

  assign w_elig  = (state_q == ST_FETCH) && (w_cnt_q < wt_tot_q) && !w_full &&
                   (CW'(w_count) + infl_w < CW'(FIFO_DEPTH));
  assign b_elig  = (state_q == ST_FETCH) && (b_cnt_q < b_tot_q) && !b_full &&
                   (CW'(b_count) + infl_b < CW'(FIFO_DEPTH));
  assign grant_w = w_elig && (!b_elig || !rr_q);
  assign grant_b = b_elig && !grant_w;
  assign mem_req = grant_w || grant_b;

  always_comb begin
    mem_addr = '0;
    if (grant_w)      mem_addr = AW'(WBASE) + AW'(w_cnt_q);
    else if (grant_b) mem_addr = AW'(BBASE) + AW'(b_cnt_q);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    prev_d   = prev_q;
    wt_tot_d = wt_tot_q;
    b_tot_d  = b_tot_q;
    w_cnt_d  = w_cnt_q;
    b_cnt_d  = b_cnt_q;
    rr_d     = rr_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_CFG;
        idx_d    = '0;
        wt_tot_d = '0;
        b_tot_d  = '0;
        w_cnt_d  = '0;
        b_cnt_d  = '0;
        rr_d     = 1'b0;
      end
      ST_CFG: begin
        if (idx_q == nl_eff) begin
          state_d = ST_FETCH;
        end else begin
          wt_tot_d = wt_tot_q + TOT_W'(n_prev) * TOT_W'(n_cur);
          b_tot_d  = b_tot_q + TOT_W'(n_cur);
          prev_d   = n_cur;
          idx_d    = idx_q + 3'd1;
        end
      end
      ST_FETCH: begin
        if (grant_w) begin
          w_cnt_d = w_cnt_q + TOT_W'(1);
          rr_d    = 1'b1;
        end else if (grant_b) begin
          b_cnt_d = b_cnt_q + TOT_W'(1);
          rr_d    = 1'b0;
        end
        if (w_cnt_q == wt_tot_q && b_cnt_q == b_tot_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (w_empty && b_empty && pv_q == '0) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pv_d    = '0;
    pt_d    = '0;
    pv_d[0] = mem_req;
    pt_d[0] = grant_b ? TAG_B : TAG_W;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pt_d[i] = pt_q[i-1];
    end
  end

  assign w_push = mem_rvalid && pv_q[MEM_LAT-1] && (pt_q[MEM_LAT-1] == TAG_W);
  assign b_push = mem_rvalid && pv_q[MEM_LAT-1] && (pt_q[MEM_LAT-1] == TAG_B);

  always_comb begin
    underrun_d = underrun_q;
    if ((weight_en && w_empty) || (bias_en && b_empty)) underrun_d = 1'b1;
    if (start_acc) underrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      prev_q     <= '0;
      wt_tot_q   <= '0;
      b_tot_q    <= '0;
      w_cnt_q    <= '0;
      b_cnt_q    <= '0;
      rr_q       <= 1'b0;
      pv_q       <= '0;
      pt_q       <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prev_q     <= prev_d;
      wt_tot_q   <= wt_tot_d;
      b_tot_q    <= b_tot_d;
      w_cnt_q    <= w_cnt_d;
      b_cnt_q    <= b_cnt_d;
      rr_q       <= rr_d;
      pv_q       <= pv_d;
      pt_q       <= pt_d;
      underrun_q <= underrun_d;
    end
  end

  param_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_wt_fifo (
    .clk(clk), .reset(reset), .push(w_push), .pop(weight_en), .wdata(mem_rdata),
    .head(wt_in), .full(w_full), .empty(w_empty), .count(w_count)
  );

  param_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk(clk), .reset(reset), .push(b_push), .pop(bias_en), .wdata(mem_rdata),
    .head(bias_in), .full(b_full), .empty(b_empty), .count(b_count)
  );

  assign wt_valid   = !w_empty;
  assign bias_valid = !b_empty;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign underrun   = underrun_q;

`ifdef PARAM_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (weight_en && !w_empty) csum_d = csum_d + wt_in;
    if (bias_en && !b_empty)   csum_d = csum_d + bias_in;
    if (start_acc)             csum_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign param_csum = csum_q;
`else
  assign param_csum = '0;
`endif

endmodule

// File: tb/tb_param_prefetch_unit.sv
// Directed bench for param_prefetch_unit with a fixed-latency memory model.
module tb_param_prefetch_unit;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 15;
  localparam int unsigned WBASE = 0;
  localparam int unsigned BBASE = 20480;
`ifdef PARAM_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [5:0] no_layers = '0, n_in = '0, nl1 = '0, nl2 = '0, nl3 = '0, nl4 = '0, nl5 = '0;
  logic weight_en = 1'b0, bias_en = 1'b0;
  logic mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_req, wt_valid, bias_valid, busy, done, underrun;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] wt_in, bias_in, param_csum;

  int checks = 0, failures = 0;
  bit csum_mode = 1'b0;
  logic rv1 = 1'b0;
  logic [AW-1:0] ra1 = '0;
  int nw, nb, aerr, derr, ndone, pw, pb, post;
  logic [DW-1:0] sum, csum_done;

  param_prefetch_unit #(.DW(DW), .AW(AW), .FIFO_DEPTH(4), .MEM_LAT(2),
                        .WBASE(WBASE), .BBASE(BBASE)) dut (
    .clk(clk), .reset(reset), .start(start), .no_layers(no_layers), .n_in(n_in),
    .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4), .nl5(nl5),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .weight_en(weight_en), .bias_en(bias_en), .wt_in(wt_in), .bias_in(bias_in),
    .wt_valid(wt_valid), .bias_valid(bias_valid), .busy(busy), .done(done),
    .underrun(underrun), .param_csum(param_csum)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    if (csum_mode) begin
      if (a == AW'(WBASE))          return 16'hFFFF;
      else if (a == AW'(WBASE + 1)) return 16'h0002;
      else if (a == AW'(BBASE))     return 16'h0001;
      else                          return 16'h0000;
    end
    return DW'(a) * 16'd7 + 16'h0101;
  endfunction

  // Two-cycle memory; deliberately not reset so stale returns reach the DUT.
  always @(posedge clk) begin
    rv1        <= mem_req;
    ra1        <= mem_addr;
    mem_rvalid <= rv1;
    mem_rdata  <= rv1 ? mem_data(ra1) : '0;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input bit pop_w, input bit pop_b);
    if (mem_req) begin
      if (mem_addr >= AW'(BBASE)) begin
        if (mem_addr != AW'(BBASE + nb)) aerr++;
        nb++;
      end else begin
        if (mem_addr != AW'(WBASE + nw)) aerr++;
        nw++;
      end
    end
    if (done) begin
      ndone++;
      csum_done = param_csum;
    end
    weight_en = pop_w && wt_valid;
    bias_en   = pop_b && bias_valid;
    if (weight_en) begin
      if (wt_in !== mem_data(AW'(WBASE + pw))) derr++;
      sum = sum + mem_data(AW'(WBASE + pw));
      pw++;
    end
    if (bias_en) begin
      if (bias_in !== mem_data(AW'(BBASE + pb))) derr++;
      sum = sum + mem_data(AW'(BBASE + pb));
      pb++;
    end
    step();
  endtask

  task automatic begin_run(input logic [5:0] nlay, ni, a, b, c, d, e);
    no_layers = nlay; n_in = ni; nl1 = a; nl2 = b; nl3 = c; nl4 = d; nl5 = e;
    nw = 0; nb = 0; aerr = 0; derr = 0; ndone = 0; pw = 0; pb = 0;
    sum = '0; csum_done = '0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain;
    post = 0;
    for (int i = 0; i < 3000; i++) begin
      observe(1'b1, 1'b1);
      if (ndone > 0) post++;
      if (post > 5) break;
    end
    weight_en = 1'b0;
    bias_en   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(); step();
    checks++;
    if ({mem_req, busy, done, underrun, wt_valid, bias_valid, wt_in, bias_in, param_csum, mem_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%0b busy=%0b done=%0b wt=%0h b=%0h csum=%0h required all 0",
               mem_req, busy, done, wt_in, bias_in, param_csum);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic;
    begin_run(6'd1, 6'd4, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0);
    drain();
    checks++; if (nw !== 8) begin failures++; $display("FAIL basic_wreqs: got %0d required 8", nw); end
    checks++; if (nb !== 2) begin failures++; $display("FAIL basic_breqs: got %0d required 2", nb); end
    checks++; if (aerr !== 0) begin failures++; $display("FAIL basic_addr_order: got %0d errors required 0", aerr); end
    checks++; if (derr !== 0 || pw !== 8 || pb !== 2) begin failures++; $display("FAIL basic_pop_data: errs=%0d pw=%0d pb=%0d required 0/8/2", derr, pw, pb); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL basic_done_pulses: got %0d required 1", ndone); end
    checks++; if ({underrun, busy} !== 2'b00) begin failures++; $display("FAIL basic_idle_flags: got %b required 00", {underrun, busy}); end
    checks++; if (csum_done !== (CSUM_ON ? sum : 16'h0)) begin failures++; $display("FAIL basic_csum: got %0h required %0h", csum_done, CSUM_ON ? sum : 16'h0); end
  endtask

  task automatic test_backpressure;
    begin_run(6'd1, 6'd8, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0);
    repeat (25) observe(1'b0, 1'b0);
    checks++; if (nw !== 4 || nb !== 2) begin failures++; $display("FAIL fill_reqs: got w=%0d b=%0d required 4/2", nw, nb); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fill_req_stalled: got %0b required 0", mem_req); end
    checks++; if (wt_in !== mem_data(AW'(WBASE)) || bias_in !== mem_data(AW'(BBASE))) begin
      failures++; $display("FAIL fill_heads: got %0h/%0h required %0h/%0h", wt_in, bias_in, mem_data(AW'(WBASE)), mem_data(AW'(BBASE)));
    end
    observe(1'b1, 1'b0);
    checks++; if ({mem_req, mem_addr} !== {1'b1, AW'(WBASE + 4)}) begin
      failures++; $display("FAIL credit_resume: got req=%0b addr=%0d required 1/%0d", mem_req, mem_addr, WBASE + 4);
    end
    checks++; if (wt_in !== mem_data(AW'(WBASE + 1))) begin failures++; $display("FAIL pop_order: got %0h required %0h", wt_in, mem_data(AW'(WBASE + 1))); end
    drain();
    checks++; if (nw !== 16 || nb !== 2) begin failures++; $display("FAIL bp_total_reqs: got w=%0d b=%0d required 16/2", nw, nb); end
    checks++; if (derr !== 0 || aerr !== 0 || pw !== 16) begin failures++; $display("FAIL bp_stream: derr=%0d aerr=%0d pw=%0d required 0/0/16", derr, aerr, pw); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL bp_done: got %0d required 1", ndone); end
  endtask

  task automatic test_underrun;
    checks++; if ({underrun, wt_valid, wt_in} !== '0) begin failures++; $display("FAIL underrun_pre: got u=%0b v=%0b wt=%0h required 0", underrun, wt_valid, wt_in); end
    weight_en = 1'b1;
    step();
    weight_en = 1'b0;
    checks++; if ({underrun, wt_valid, wt_in} !== {1'b1, 1'b0, 16'h0}) begin failures++; $display("FAIL underrun_set: got u=%0b v=%0b wt=%0h required 1/0/0", underrun, wt_valid, wt_in); end
    repeat (3) step();
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_sticky: got %0b required 1", underrun); end
  endtask

  task automatic test_layer_bounds;
    int reqs;
    reqs = 0;
    no_layers = 6'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({underrun, busy} !== 2'b01) begin failures++; $display("FAIL zero_start_flags: got %b required 01", {underrun, busy}); end
    for (int k = 1; k <= 4; k++) begin
      if (mem_req) reqs++;
      step();
      checks++;
      if (done !== (k == 3)) begin failures++; $display("FAIL zero_done_k%0d: got %0b required %0b", k, done, k == 3); end
    end
    checks++; if (reqs !== 0) begin failures++; $display("FAIL zero_reqs: got %0d required 0", reqs); end
    begin_run(6'd7, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6);
    drain();
    checks++; if (nw !== 70 || nb !== 20) begin failures++; $display("FAIL clamp_totals: got w=%0d b=%0d required 70/20", nw, nb); end
    checks++; if (derr !== 0 || aerr !== 0 || ndone !== 1) begin failures++; $display("FAIL clamp_stream: derr=%0d aerr=%0d done=%0d required 0/0/1", derr, aerr, ndone); end
  endtask

  task automatic test_reset_midrun;
    begin_run(6'd1, 6'd4, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0);
    for (int i = 0; i < 20; i++) begin
      if (nw + nb >= 2) break;
      observe(1'b0, 1'b0);
    end
    checks++; if (nw + nb !== 2) begin failures++; $display("FAIL midrun_inflight: got %0d required 2", nw + nb); end
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, done, underrun, wt_valid, bias_valid, wt_in, bias_in, param_csum, mem_addr} !== '0) begin
      failures++; $display("FAIL midrun_async_clear: got req=%0b busy=%0b wt=%0h b=%0h required all 0", mem_req, busy, wt_in, bias_in);
    end
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({wt_valid, bias_valid, busy, mem_req} !== 4'b0000) begin failures++; $display("FAIL stale_rvalid_c%0d: got %b required 0000", k, {wt_valid, bias_valid, busy, mem_req}); end
    end
    begin_run(6'd1, 6'd4, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0);
    drain();
    checks++; if (nw !== 8 || nb !== 2 || derr !== 0 || aerr !== 0 || ndone !== 1) begin
      failures++; $display("FAIL rerun_clean: w=%0d b=%0d derr=%0d aerr=%0d done=%0d required 8/2/0/0/1", nw, nb, derr, aerr, ndone);
    end
  endtask

  task automatic test_checksum;
    csum_mode = 1'b1;
    begin_run(6'd1, 6'd2, 6'd1, 6'd0, 6'd0, 6'd0, 6'd0);
    drain();
    checks++; if (derr !== 0 || pw !== 2 || pb !== 1) begin failures++; $display("FAIL csum_stream: derr=%0d pw=%0d pb=%0d required 0/2/1", derr, pw, pb); end
    checks++; if (csum_done !== (CSUM_ON ? 16'h0002 : 16'h0000)) begin failures++; $display("FAIL csum_at_done: got %0h required %0h", csum_done, CSUM_ON ? 16'h0002 : 16'h0000); end
    checks++; if (param_csum !== (CSUM_ON ? 16'h0002 : 16'h0000)) begin failures++; $display("FAIL csum_hold: got %0h required %0h", param_csum, CSUM_ON ? 16'h0002 : 16'h0000); end
    csum_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_underrun();
    test_layer_bounds();
    test_reset_midrun();
    test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
